// File: rtl/pe_stage_feeder.sv
// Ping-pong frame buffer feeding a radix-2 butterfly PE with four-lane groups and twiddle addresses.
// Define PE_FEEDER_BITREV_EN to store samples at bit-reversed write addresses (first-stage use).
module pe_stage_feeder #(
  parameter int WIDTH      = 16,
  parameter int LOGN       = 4,
  parameter int STRIDE_LOG = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [2*WIDTH-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     out0,
  output logic [WIDTH-1:0]     out1,
  output logic [WIDTH-1:0]     out2,
  output logic [WIDTH-1:0]     out3,
  output logic                 out_valid,
  output logic                 out_first,
  output logic [LOGN-2:0]      tw_addr,
  output logic                 tw_en,
  output logic                 bypass_n
);

  localparam int N = 1 << LOGN;
  localparam int S = 1 << STRIDE_LOG;
  localparam logic [LOGN-1:0] SMASK  = LOGN'(S - 1);
  localparam logic [LOGN-1:0] SPAN   = LOGN'(S);
  localparam logic [LOGN-1:0] W_LAST = LOGN'(N - 1);
  localparam logic [LOGN-2:0] J_LAST = '1;
  localparam logic [LOGN-2:0] J_ONE  = (LOGN-1)'(1);

  typedef enum logic {IDLE, ISSUE} state_t;

  function automatic logic [LOGN-1:0] grp_base(input logic [LOGN-2:0] j);
    logic [LOGN-1:0] jx;
    jx = {1'b0, j};
    return ((jx >> STRIDE_LOG) << (STRIDE_LOG + 1)) | (jx & SMASK);
  endfunction

  function automatic logic [LOGN-2:0] twid(input logic [LOGN-2:0] j);
    logic [LOGN-2:0] jm;
    jm = j & SMASK[LOGN-2:0];
    return jm << (LOGN - 1 - STRIDE_LOG);
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = a[LOGN-1-b];
    return r;
  endfunction

  logic [2*WIDTH-1:0] bank_q [2][N];
  logic [LOGN-1:0]    wcnt_q, wcnt_d, waddr;
  logic               wr_bank_q, wr_bank_d, rd_bank_q;
  logic [1:0]         full_q, full_d;
  state_t             state_q;
  logic [LOGN-2:0]    j_q;
  logic               wr_acc, issue_last;
  logic [LOGN-1:0]    rd_lo, rd_hi;
  logic [2*WIDTH-1:0] samp_lo, samp_hi;
  logic [WIDTH-1:0]   out0_q, out1_q, out2_q, out3_q;
  logic               out_valid_q, out_first_q, bypass_q, tw_en_q;
  logic [LOGN-2:0]    tw_addr_q;

  assign s_ready    = Reset_n & ~full_q[wr_bank_q];
  assign wr_acc     = s_valid & s_ready;
  assign issue_last = (state_q == ISSUE) && (j_q == J_LAST);

`ifdef PE_FEEDER_BITREV_EN
  assign waddr = bitrev(wcnt_q);
`else
  assign waddr = wcnt_q;
`endif

  // Write side: fill the current bank, hand it to the reader once the last sample lands.
  always_comb begin
    wcnt_d    = wcnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    if (wr_acc) begin
      if (wcnt_q == W_LAST) begin
        wcnt_d            = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wcnt_d = wcnt_q + LOGN'(1);
      end
    end
    if (issue_last) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wcnt_q    <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      wcnt_q    <= wcnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
    end
  end

  // Sample storage is never reset; only the full flags decide what is valid.
  always_ff @(posedge Clk) begin
    if (wr_acc) bank_q[wr_bank_q][waddr] <= s_data;
  end

  assign rd_lo   = grp_base(j_q);
  assign rd_hi   = rd_lo + SPAN;
  assign samp_lo = bank_q[rd_bank_q][rd_lo];
  assign samp_hi = bank_q[rd_bank_q][rd_hi];

  // Read FSM: twiddle address leads its group's lane data by one cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      j_q         <= '0;
      rd_bank_q   <= 1'b0;
      tw_en_q     <= 1'b0;
      tw_addr_q   <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      bypass_q    <= 1'b0;
    end else begin
      out_valid_q <= (state_q == ISSUE);
      out_first_q <= (state_q == ISSUE) && (j_q == '0);
      bypass_q    <= (state_q == ISSUE) && (twid(j_q) != '0);
      if (state_q == ISSUE) begin
        out0_q <= samp_lo[2*WIDTH-1:WIDTH];
        out1_q <= samp_hi[2*WIDTH-1:WIDTH];
        out2_q <= samp_lo[WIDTH-1:0];
        out3_q <= samp_hi[WIDTH-1:0];
      end else begin
        out0_q <= '0;
        out1_q <= '0;
        out2_q <= '0;
        out3_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q   <= ISSUE;
            j_q       <= '0;
            tw_en_q   <= 1'b1;
            tw_addr_q <= twid('0);
          end else begin
            tw_en_q   <= 1'b0;
            tw_addr_q <= '0;
          end
        end
        ISSUE: begin
          if (j_q == J_LAST) begin
            rd_bank_q <= ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              j_q       <= '0;
              tw_en_q   <= 1'b1;
              tw_addr_q <= twid('0);
            end else begin
              state_q   <= IDLE;
              tw_en_q   <= 1'b0;
              tw_addr_q <= '0;
            end
          end else begin
            j_q       <= j_q + J_ONE;
            tw_en_q   <= 1'b1;
            tw_addr_q <= twid(j_q + J_ONE);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign bypass_n  = bypass_q;
  assign tw_addr   = tw_addr_q;
  assign tw_en     = tw_en_q;

endmodule

// File: tb/tb_pe_stage_feeder.sv
// Bench for pe_stage_feeder: two instances (stride 8 and stride 1) share one input stream
// and are checked against a frame-level butterfly-pair model.
module tb_pe_stage_feeder;
  localparam int W = 16;
  localparam int N = 16;

  typedef struct {
    logic [W-1:0] a, b, c, d;
    logic [2:0]   t;
    logic         first, last;
    int           due;
  } grp_t;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [2*W-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          rdy [2];
  logic [W-1:0]  o0 [2], o1 [2], o2 [2], o3 [2];
  logic          ov [2], ofst [2], byp [2], twe [2];
  logic [2:0]    twa [2];
  int            checks = 0, errors = 0, cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  pe_stage_feeder #(.WIDTH(W), .LOGN(4), .STRIDE_LOG(3)) dut_s8 (
    .Clk(Clk), .Reset_n(Reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]),
    .out0(o0[0]), .out1(o1[0]), .out2(o2[0]), .out3(o3[0]), .out_valid(ov[0]),
    .out_first(ofst[0]), .tw_addr(twa[0]), .tw_en(twe[0]), .bypass_n(byp[0]));

  pe_stage_feeder #(.WIDTH(W), .LOGN(4), .STRIDE_LOG(0)) dut_s1 (
    .Clk(Clk), .Reset_n(Reset_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]),
    .out0(o0[1]), .out1(o1[1]), .out2(o2[1]), .out3(o3[1]), .out_valid(ov[1]),
    .out_first(ofst[1]), .tw_addr(twa[1]), .tw_en(twe[1]), .bypass_n(byp[1]));

  function automatic logic [3:0] brev4(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  // Reference model per instance: collect a frame, then list its butterfly pairs (k, k+S)
  // in ascending k with twiddle (k mod S) * (N/2)/S, due on consecutive edges.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int S = (g == 0) ? 8 : 1;
    grp_t          q [$];
    logic [2*W-1:0] fbuf [N];
    int            wc = 0, pend = 0, gi, base, wa;
    grp_t          e;

    always @(negedge Clk) begin
      if (!Reset_n) begin
        q.delete();
        wc   = 0;
        pend = 0;
      end else begin
        if (ov[g]) begin
          checks++;
          if (q.size() == 0 || q[0].due != cyc) begin
            errors++;
            $display("FAIL unexpected_out dut%0d edge %0d: out_valid=1, want 0", g, cyc);
          end else begin
            e = q.pop_front();
            if (o0[g] !== e.a || o1[g] !== e.b || o2[g] !== e.c || o3[g] !== e.d ||
                ofst[g] !== e.first || byp[g] !== (e.t != 0)) begin
              errors++;
              $display("FAIL group dut%0d edge %0d: got %h %h %h %h first=%b byp=%b, want %h %h %h %h first=%b byp=%b",
                       g, cyc, o0[g], o1[g], o2[g], o3[g], ofst[g], byp[g],
                       e.a, e.b, e.c, e.d, e.first, (e.t != 0));
            end
            if (e.last) pend--;
          end
        end else if (q.size() > 0 && q[0].due == cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_out dut%0d edge %0d: out_valid=0, want 1", g, cyc);
          e = q.pop_front();
          if (e.last) pend--;
        end
        checks++;
        if (q.size() > 0 && q[0].due == cyc + 1) begin
          if (twe[g] !== 1'b1 || twa[g] !== q[0].t) begin
            errors++;
            $display("FAIL twiddle dut%0d edge %0d: got en=%b addr=%0d, want en=1 addr=%0d",
                     g, cyc, twe[g], twa[g], q[0].t);
          end
        end else if (twe[g] !== 1'b0) begin
          errors++;
          $display("FAIL tw_en_idle dut%0d edge %0d: got %b, want 0", g, cyc, twe[g]);
        end
        checks++;
        if (rdy[g] !== (pend < 2)) begin
          errors++;
          $display("FAIL s_ready dut%0d edge %0d: got %b, want %b", g, cyc, rdy[g], (pend < 2));
        end
        if (s_valid && rdy[g]) begin
`ifdef PE_FEEDER_BITREV_EN
          wa = int'(brev4(4'(wc)));
`else
          wa = wc;
`endif
          fbuf[wa] = s_data;
          wc++;
          if (wc == N) begin
            wc   = 0;
            pend++;
            base = cyc + 3;
            if (q.size() > 0 && q[$].due + 1 > base) base = q[$].due + 1;
            gi = 0;
            for (int k = 0; k < N; k++) begin
              if ((k & S) == 0) begin
                e.a     = fbuf[k][2*W-1:W];
                e.b     = fbuf[k+S][2*W-1:W];
                e.c     = fbuf[k][W-1:0];
                e.d     = fbuf[k+S][W-1:0];
                e.t     = 3'((k % S) * ((N / 2) / S));
                e.first = (gi == 0);
                e.last  = (gi == N / 2 - 1);
                e.due   = base + gi;
                q.push_back(e);
                gi++;
              end
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [2*W-1:0] v);
    @(posedge Clk); #1;
    s_data  = v;
    s_valid = 1'b1;
  endtask

  task automatic idle_in(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      s_valid = 1'b0;
      s_data  = $urandom;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (mon[0].q.size() == 0 && mon[1].q.size() == 0) break;
      @(negedge Clk);
    end
    checks++;
    if (mon[0].q.size() != 0 || mon[1].q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d/%0d groups, want 0", mon[0].q.size(), mon[1].q.size());
    end
    idle_in(3);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b0 || ov[d] !== 1'b0 || twe[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: ready=%b valid=%b tw_en=%b, want 0 0 0", d, rdy[d], ov[d], twe[d]);
      end
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset dut%0d: got %b, want 1", d, rdy[d]);
      end
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({o0[d], o1[d], o2[d], o3[d]} !== '0 || ov[d] !== 1'b0 || ofst[d] !== 1'b0 ||
            twe[d] !== 1'b0 || twa[d] !== 3'd0 || byp[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs dut%0d cycle %0d: got %h %h %h %h v=%b f=%b twe=%b twa=%0d b=%b, want all 0",
                   d, c, o0[d], o1[d], o2[d], o3[d], ov[d], ofst[d], twe[d], twa[d], byp[d]);
        end
      end
    end
  endtask

  task automatic test_defaults();
    for (int i = 0; i < N; i++) send({16'(i), 16'h8000 | 16'(i)});
    idle_in(1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3 * N; i++) send($urandom);
    idle_in(1);
    wait_drain();
  endtask

  task automatic test_gap();
    for (int i = 0; i < 8; i++) send($urandom);
    idle_in(20);
    for (int i = 0; i < 8; i++) send($urandom);
    idle_in(1);
    wait_drain();
  endtask

  task automatic test_reset_mid_drain();
    bit hit = 0;
    for (int i = 0; i < N; i++) send($urandom);
    idle_in(1);
    for (int i = 0; i < 40; i++) begin
      if (mon[0].q.size() == 5) begin
        hit = 1;
        break;
      end
      @(posedge Clk); #1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_group3: drain never reached group 3, pending %0d", mon[0].q.size());
    end
    #2 Reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o0[d], o1[d], o2[d], o3[d]} !== '0 || ov[d] !== 1'b0 || ofst[d] !== 1'b0 ||
          twe[d] !== 1'b0 || byp[d] !== 1'b0 || rdy[d] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h %h %h %h v=%b twe=%b rdy=%b, want all 0",
                 d, o0[d], o1[d], o2[d], o3[d], ov[d], twe[d], rdy[d]);
      end
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    for (int i = 0; i < N; i++) send($urandom);
    idle_in(1);
    wait_drain();
  endtask

`ifdef PE_FEEDER_BITREV_EN
  task automatic test_bitrev();
    logic [3:0] v;
    for (int i = 0; i < N; i++) begin
      v = brev4(4'(i));
      send({12'h0, v, 16'h8000 | {12'h0, v}});
    end
    idle_in(1);
    wait_drain();
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_back_to_back();
    test_gap();
    test_reset_mid_drain();
`ifdef PE_FEEDER_BITREV_EN
    test_bitrev();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
